// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Sequencing FSM for a multi-cycle RISC-V style datapath. Each instruction
// passes through IF -> ID -> EX [-> MEM] [-> WB]. The opcode is latched in
// ID, and every datapath enable and mux select is derived from the current
// state and that latched opcode. Data memory accesses wait on a
// variable-latency ready handshake that has a bounded timeout. Retired
// instructions are counted.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        run enable (sampled in IDLE and on the retiring cycle)
//   Op_i[6:0]      opcode field of the instruction register
//   Zero_i         ALU zero flag (branch decision)
//   mem_ready_i    data memory completed the current access
//   PCWrite_o      PC load enable
//   PCSrc_o        PC mux select: 0 = pc+4, 1 = branch target
//   IRWrite_o      instruction register load enable
//   RegWrite_o     register-file write enable
//   MemRead_o      data memory read request
//   MemWrite_o     data memory write request
//   MemtoReg_o     writeback select: 0 = ALU, 1 = memory
//   ALUSrc_o       ALU B select: 0 = rs2, 1 = immediate
//   ALUOp_o[1:0]   10 = R-type, 01 = branch compare, 00 = add
//   state_o[2:0]   current state code
//   instr_count_o  retired-instruction count (wraps)
//   illegal_o      sticky: unsupported opcode decoded
//   timeout_o      sticky: memory wait timed out
// ---------------------------------------------------------------------------
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       Op_i,
   input  logic             Zero_i,
   input  logic             mem_ready_i,
   output logic             PCWrite_o,
   output logic             PCSrc_o,
   output logic             IRWrite_o,
   output logic             RegWrite_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             MemtoReg_o,
   output logic             ALUSrc_o,
   output logic [1:0]       ALUOp_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instr_count_o,
   output logic             illegal_o,
   output logic             timeout_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // The final allowed wait cycle: the counter starts at 0 on MEM entry, so
   // MEM_TIMEOUT cycles without ready end with the counter at MEM_TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic [6:0]       op_reg;
   logic [7:0]       wait_cnt_reg;
   logic [CNT_W-1:0] instr_count_reg;
   logic             illegal_reg;
   logic             timeout_reg;

   logic is_r, is_i, is_ld, is_st, is_br, id_legal;
   logic retire, set_ill, set_to, clr_wait, inc_wait;

   // Class of the latched instruction (valid from EX onward)
   assign is_r  = (op_reg == OP_R);
   assign is_i  = (op_reg == OP_I);
   assign is_ld = (op_reg == OP_LOAD);
   assign is_st = (op_reg == OP_STORE);
   assign is_br = (op_reg == OP_BRANCH);

   // Legality of the opcode being decoded right now (used in ID only)
   assign id_legal = (Op_i == OP_R) || (Op_i == OP_I) || (Op_i == OP_LOAD) ||
                     (Op_i == OP_STORE) || (Op_i == OP_BRANCH);

   always_comb begin
      state_next = state_reg;
      PCWrite_o  = 1'b0;
      PCSrc_o    = 1'b0;
      IRWrite_o  = 1'b0;
      RegWrite_o = 1'b0;
      MemRead_o  = 1'b0;
      MemWrite_o = 1'b0;
      MemtoReg_o = 1'b0;
      ALUSrc_o   = 1'b0;
      ALUOp_o    = 2'b00;
      retire     = 1'b0;
      set_ill    = 1'b0;
      set_to     = 1'b0;
      clr_wait   = 1'b0;
      inc_wait   = 1'b0;

      // ALU controls are held for the whole execute/memory/writeback span
      if (state_reg == S_EX || state_reg == S_MEM || state_reg == S_WB) begin
         ALUSrc_o = is_i | is_ld | is_st;
         ALUOp_o  = is_r ? 2'b10 : (is_br ? 2'b01 : 2'b00);
      end

      case (state_reg)
         S_IDLE: begin
            if (start_i) state_next = S_IF;
         end
         S_IF: begin
            IRWrite_o  = 1'b1;
            state_next = S_ID;
         end
         S_ID: begin
            state_next = id_legal ? S_EX : S_ERR;
            set_ill    = ~id_legal;
         end
         S_EX: begin
            if (is_br) begin
               PCWrite_o = 1'b1;
               PCSrc_o   = Zero_i;
               retire    = 1'b1;
            end else if (is_ld || is_st) begin
               clr_wait   = 1'b1;
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            MemRead_o  = is_ld;
            MemWrite_o = is_st;
            // Ready has priority over a timeout firing in the same cycle
            if (mem_ready_i) begin
               if (is_st) begin
                  PCWrite_o = 1'b1;
                  retire    = 1'b1;
               end else begin
                  state_next = S_WB;
               end
            end else begin
               inc_wait = 1'b1;
               if (wait_cnt_reg == WAIT_LAST) begin
                  state_next = S_ERR;
                  set_to     = 1'b1;
               end
            end
         end
         S_WB: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = is_ld;
            PCWrite_o  = 1'b1;
            retire     = 1'b1;
         end
         S_ERR: begin
            state_next = S_ERR;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // A retiring instruction either chains into the next fetch or parks
      if (retire) state_next = start_i ? S_IF : S_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg       <= S_IDLE;
         op_reg          <= 7'd0;
         wait_cnt_reg    <= 8'd0;
         instr_count_reg <= '0;
         illegal_reg     <= 1'b0;
         timeout_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_ID) op_reg <= Op_i;
         if (clr_wait)      wait_cnt_reg <= 8'd0;
         else if (inc_wait) wait_cnt_reg <= wait_cnt_reg + 8'd1;
         if (retire)  instr_count_reg <= instr_count_reg + CNT_W'(1);
         if (set_ill) illegal_reg <= 1'b1;
         if (set_to)  timeout_reg <= 1'b1;
      end
   end

   assign state_o       = state_reg;
   assign instr_count_o = instr_count_reg;
   assign illegal_o     = illegal_reg;
   assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Drives instruction-level stimulus (opcode class, memory wait count, branch
// outcome, start behaviour) into two instances of multicycle_control, one
// with a 32-bit counter and one with a 4-bit counter, and compares every
// cycle against the expected cycle trace of each instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int MEM_TIMEOUT = 15;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [6:0]  Op_i = 7'd0;
   logic        Zero_i = 1'b0;
   logic        mem_ready_i = 1'b0;

   logic        PCWrite_o, PCSrc_o, IRWrite_o, RegWrite_o, MemRead_o;
   logic        MemWrite_o, MemtoReg_o, ALUSrc_o, illegal_o, timeout_o;
   logic [1:0]  ALUOp_o;
   logic [2:0]  state_o;
   logic [31:0] instr_count;

   logic        PCWrite4, PCSrc4, IRWrite4, RegWrite4, MemRead4;
   logic        MemWrite4, MemtoReg4, ALUSrc4, illegal4, timeout4;
   logic [1:0]  ALUOp4;
   logic [2:0]  state4;
   logic [3:0]  instr_count4;

   logic [14:0] obs_ctrl, obs_ctrl4;

   // Reference model state
   logic [31:0] cnt = 32'd0;
   logic        flag_ill = 1'b0;
   logic        flag_to = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
      .Zero_i(Zero_i), .mem_ready_i(mem_ready_i),
      .PCWrite_o(PCWrite_o), .PCSrc_o(PCSrc_o), .IRWrite_o(IRWrite_o),
      .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
      .state_o(state_o), .instr_count_o(instr_count),
      .illegal_o(illegal_o), .timeout_o(timeout_o)
   );

   multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
      .Zero_i(Zero_i), .mem_ready_i(mem_ready_i),
      .PCWrite_o(PCWrite4), .PCSrc_o(PCSrc4), .IRWrite_o(IRWrite4),
      .RegWrite_o(RegWrite4), .MemRead_o(MemRead4), .MemWrite_o(MemWrite4),
      .MemtoReg_o(MemtoReg4), .ALUSrc_o(ALUSrc4), .ALUOp_o(ALUOp4),
      .state_o(state4), .instr_count_o(instr_count4),
      .illegal_o(illegal4), .timeout_o(timeout4)
   );

   assign obs_ctrl  = {state_o, PCWrite_o, PCSrc_o, IRWrite_o, RegWrite_o,
                       MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, ALUOp_o,
                       illegal_o, timeout_o};
   assign obs_ctrl4 = {state4, PCWrite4, PCSrc4, IRWrite4, RegWrite4,
                       MemRead4, MemWrite4, MemtoReg4, ALUSrc4, ALUOp4,
                       illegal4, timeout4};

   // Expected control vector, same field order as obs_ctrl
   function automatic logic [14:0] mk(input logic [2:0] st, input logic pcw,
                                      input logic pcs, input logic irw,
                                      input logic rw, input logic mr,
                                      input logic mw, input logic m2r,
                                      input logic asrc, input logic [1:0] aop);
      return {st, pcw, pcs, irw, rw, mr, mw, m2r, asrc, aop, flag_ill, flag_to};
   endfunction

   function automatic bit legal_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock: inputs already driven; sample at the falling edge, then
   // advance past the next rising edge.
   task automatic cyc(input string tag, input logic [14:0] e);
      @(negedge clk);
      chk({tag, " ctrl"},   {17'd0, obs_ctrl},  {17'd0, e});
      chk({tag, " ctrl4"},  {17'd0, obs_ctrl4}, {17'd0, e});
      chk({tag, " count"},  instr_count, cnt);
      chk({tag, " count4"}, {28'd0, instr_count4}, {28'd0, cnt[3:0]});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i   = 1'b1;
      start_i = 1'($urandom);
      @(posedge clk);
      #1;
      rst_i    = 1'b0;
      cnt      = 32'd0;
      flag_ill = 1'b0;
      flag_to  = 1'b0;
      start_i  = 1'b0;
      cyc("RESET", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
   endtask

   // n idle cycles with start low, then one with start high (leaves IF next)
   task automatic idle_then_go(input int n);
      for (int i = 0; i < n; i++) begin
         start_i = 1'b0;
         Op_i    = 7'($urandom);
         cyc("IDLE", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
      end
      start_i = 1'b1;
      cyc("IDLE go", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
   endtask

   task automatic err_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         start_i     = 1'($urandom);
         mem_ready_i = 1'($urandom);
         Op_i        = 7'($urandom);
         cyc("ERR", mk(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
      end
   endtask

   // Runs one instruction from IF. status: 0 retired, 1 ended in ERR,
   // 2 aborted by reset during MEM cycle number rst_k.
   task automatic run_instr(input logic [6:0] op, input int waits, input bit zero,
                            input bit start_after, input int rst_k, output int status);
      bit r, ii, ld, st, br, asrc, rdy;
      logic [1:0] aop;
      r  = (op == OP_R);
      ii = (op == OP_I);
      ld = (op == OP_LOAD);
      st = (op == OP_STORE);
      br = (op == OP_BRANCH);
      asrc = ii | ld | st;
      aop  = r ? 2'b10 : (br ? 2'b01 : 2'b00);
      status = 0;

      // IF: inputs other than the ones decoded later are don't-care
      Op_i = 7'($urandom); start_i = 1'($urandom);
      mem_ready_i = 1'($urandom); Zero_i = 1'($urandom);
      cyc("IF", mk(3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));

      Op_i = op; start_i = 1'($urandom);
      cyc("ID", mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
      if (!legal_op(op)) begin
         flag_ill = 1'b1;
         err_cycles(2);
         status = 1;
         $display("instr op=%b illegal -> ERR count=%0d", op, cnt);
         return;
      end

      Op_i = 7'($urandom);
      Zero_i = br ? zero : 1'($urandom);
      start_i = br ? start_after : 1'($urandom);
      cyc("EX", mk(3'd3, br, br & zero, 0, 0, 0, 0, 0, asrc, aop));

      if (ld || st) begin
         for (int k = 0; ; k++) begin
            rdy = (k == waits);
            mem_ready_i = rdy;
            start_i = (rdy && st) ? start_after : 1'($urandom);
            Zero_i = 1'($urandom);
            if (k == rst_k) begin
               rst_i = 1'b1;
               mem_ready_i = 1'b0;
               cyc("MEM rst", mk(3'd4, 0, 0, 0, 0, ld, st, 0, asrc, aop));
               rst_i = 1'b0;
               cnt = 32'd0; flag_ill = 1'b0; flag_to = 1'b0;
               status = 2;
               $display("instr op=%b reset in MEM cycle %0d", op, k);
               return;
            end
            cyc("MEM", mk(3'd4, st & rdy, 0, 0, 0, ld, st, 0, asrc, aop));
            if (rdy) break;
            if (k == MEM_TIMEOUT - 1) begin
               flag_to = 1'b1;
               err_cycles(2);
               status = 1;
               $display("instr op=%b timeout after %0d MEM cycles count=%0d", op, k + 1, cnt);
               return;
            end
         end
      end

      if (!br && !st) begin
         start_i = start_after;
         mem_ready_i = 1'($urandom);
         cyc("WB", mk(3'd5, 1, 0, 0, 1, 0, 0, ld, asrc, aop));
      end
      cnt = cnt + 32'd1;
      $display("instr op=%b waits=%0d zero=%0d start_after=%0d count=%0d",
               op, waits, zero, start_after, cnt);
   endtask

   initial begin
      logic [6:0] ops [5];
      logic [6:0] bad;
      int status, w, sel;
      ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;

      do_reset();
      idle_then_go(1);

      // Directed: R, LOAD with 3 waits, branches both ways, ready-wins edge
      run_instr(OP_R, 0, 0, 1, -1, status);
      run_instr(OP_LOAD, 3, 0, 1, -1, status);
      run_instr(OP_BRANCH, 0, 1, 1, -1, status);
      run_instr(OP_BRANCH, 0, 0, 1, -1, status);
      run_instr(OP_STORE, MEM_TIMEOUT - 1, 0, 1, -1, status);
      run_instr(OP_LOAD, MEM_TIMEOUT - 1, 0, 1, -1, status);
      // start dropped mid-instruction: R completes then parks in IDLE
      run_instr(OP_R, 0, 0, 0, -1, status);
      idle_then_go(2);

      // Random legal instruction stream (well over 16 retires: 4-bit wrap)
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 4);
         w = $urandom_range(0, 9);
         if (w == 8) w = MEM_TIMEOUT - 1;
         else if (w == 9) w = $urandom_range(0, 2);
         run_instr(ops[sel], w, 1'($urandom), ($urandom_range(0, 3) != 0), -1, status);
         if (status == 0 && start_i == 1'b0) idle_then_go($urandom_range(0, 2));
      end

      // STORE that never completes -> timeout, ERR persists, reset clears
      run_instr(OP_STORE, 1000, 0, 1, -1, status);
      chk("timeout status", status, 1);
      do_reset();
      idle_then_go(0);

      // Retire one, then an all-ones opcode: illegal, count unchanged
      run_instr(OP_I, 0, 0, 1, -1, status);
      run_instr(7'b1111111, 0, 0, 1, -1, status);
      chk("illegal status", status, 1);
      do_reset();

      // Random unsupported opcodes
      for (int n = 0; n < 3; n++) begin
         do bad = 7'($urandom); while (legal_op(bad));
         idle_then_go(0);
         run_instr(bad, 0, 0, 1, -1, status);
         do_reset();
      end

      // Reset during a memory wait
      idle_then_go(0);
      run_instr(OP_LOAD, 10, 0, 1, 2, status);
      chk("rst in MEM status", status, 2);
      start_i = 1'b0;
      cyc("after MEM rst", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
